// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline (load-use, branch, exception, memory wait).
// Optional memory-wait support is enabled by defining PIPE_CTRL_MEM_WAIT_EN.
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_addrc,
    input  logic             branch_taken,
    input  logic             exc_req,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             exc_ack,
    output logic             mem_timeout,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LDUSE    = 2'd1,
        MEMWAIT  = 2'd2,
        EXCFLUSH = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, next_state;
    logic       load_use;
    logic       mem_rdy_eff;
    logic [7:0] wait_cnt;

    assign load_use = ex_memread && (ex_addrc != 5'd0) &&
                      ((ex_addrc == id_rs) || (id_uses_rt && (ex_addrc == id_rt)));

`ifdef PIPE_CTRL_MEM_WAIT_EN
    assign mem_rdy_eff = mem_ready;

    // Held at zero outside MEMWAIT so the first wait cycle always starts from 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt <= 8'd0;
        else if (state != MEMWAIT)
            wait_cnt <= 8'd0;
        else
            wait_cnt <= wait_cnt + 8'd1;
    end
`else
    assign mem_rdy_eff = mem_ready | 1'b1;
    assign wait_cnt    = 8'd0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= RUN;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (!pc_we && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

    always_comb begin
        next_state  = state;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        exc_ack     = 1'b0;
        mem_timeout = 1'b0;
        case (state)
            RUN: begin
                if (exc_req) begin
                    pc_we       = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    next_state  = EXCFLUSH;
                end else if (mem_req && !mem_rdy_eff) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_we    = 1'b0;
                    exmem_we   = 1'b0;
                    next_state = MEMWAIT;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                    next_state = LDUSE;
                end
            end
            LDUSE: begin
                next_state = RUN;
            end
            MEMWAIT: begin
                // Exceptions are deliberately ignored here; RUN picks them up after release.
                if (mem_rdy_eff) begin
                    next_state = RUN;
                end else if (wait_cnt == TMO_LAST) begin
                    exmem_flush = 1'b1;
                    mem_timeout = 1'b1;
                    next_state  = RUN;
                end else begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    idex_we  = 1'b0;
                    exmem_we = 1'b0;
                end
            end
            EXCFLUSH: begin
                exc_ack     = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                next_state  = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    assign ctrl_state = state;

endmodule

`default_nettype wire
